cdb_scheduler: RTL

- Schedules the Common Data Bus (CDB) among three result producers: the add/sub unit, the mul/div unit and the load/register-bank path.
- Each producer hands results over through a valid/ready handshake into a private holding FIFO.
- A round-robin arbiter picks one FIFO head per cycle and drives it as a registered 24-bit CDB word.
- The reservation stations and register status table snoop that word.
- This block replaces ad-hoc priority logic with a fair, backpressured scheduler.

---
 rtl/cdb_pkg.sv | 64 ++++++
 rtl/cdb_slot_fifo.sv | 55 +++++
 rtl/cdb_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared definitions for the Common Data Bus scheduler:
// the CDB word layout, producer source codes and the word packing helper.
package cdb_pkg;

    localparam int CDB_W       = 24;
    localparam int CDB_DATA_W  = 16;
    localparam int CDB_REG_W   = 3;
    localparam int CDB_LABEL_W = 2;

    localparam int CDB_ZERO     = 23;
    localparam int CDB_BUSY     = 22;
    localparam int CDB_UNIT     = 21;
    localparam int CDB_LABEL_HI = 20;
    localparam int CDB_LABEL_LO = 19;
    localparam int CDB_REG_HI   = 18;
    localparam int CDB_REG_LO   = 16;
    localparam int CDB_DATA_HI  = 15;
    localparam int CDB_DATA_LO  = 0;

    // Label 2'b11 never names a reservation station; it marks load results.
    localparam logic [CDB_LABEL_W-1:0] LD_LABEL = 2'b11;

    typedef enum logic [1:0] {
        SRC_ADD = 2'd0,
        SRC_MUL = 2'd1,
        SRC_LD  = 2'd2
    } src_e;

    typedef struct packed {
        logic                   zero;
        logic                   busy;
        logic                   unit;
        logic [CDB_LABEL_W-1:0] label;
        logic [CDB_REG_W-1:0]   reg_idx;
        logic [CDB_DATA_W-1:0]  data;
    } cdb_word_t;

    function automatic cdb_word_t pack_cdb(
        input logic                   busy,
        input logic                   unit,
        input logic [CDB_LABEL_W-1:0] label,
        input logic [CDB_REG_W-1:0]   reg_idx,
        input logic [CDB_DATA_W-1:0]  data
    );
        cdb_word_t w;
        w.zero    = 1'b0;
        w.busy    = busy;
        w.unit    = unit;
        w.label   = label;
        w.reg_idx = reg_idx;
        w.data    = data;
        return w;
    endfunction

    // Round-robin search order: mul -> add -> load -> mul.
    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_MUL: return SRC_ADD;
            SRC_ADD: return SRC_LD;
            default: return SRC_MUL;
        endcase
    endfunction

endpackage

// File: rtl/cdb_slot_fifo.sv
// Small per-producer holding FIFO; the head is visible combinationally to the arbiter.
module cdb_slot_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 21,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap on their natural width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cdb_scheduler.sv
// Fair round-robin scheduler for the Common Data Bus: three buffered producers,
// one registered broadcast per cycle, snooped by the RS and register status table.
module cdb_scheduler
    import cdb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 3,
    parameter int LABEL_W    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               Clock,
    input  logic               Resetn,

    input  logic               add_valid,
    input  logic [LABEL_W-1:0] add_label,
    input  logic [REG_W-1:0]   add_reg,
    input  logic [DATA_W-1:0]  add_data,
    output logic               add_ready,

    input  logic               mul_valid,
    input  logic [LABEL_W-1:0] mul_label,
    input  logic [REG_W-1:0]   mul_reg,
    input  logic [DATA_W-1:0]  mul_data,
    output logic               mul_ready,

    input  logic               ld_valid,
    input  logic [REG_W-1:0]   ld_reg,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               ld_ready,

    output logic [CDB_W-1:0]   cdbOut,
    output logic [1:0]         grant_src,
    output logic [15:0]        bcast_count
);

    localparam int ENTRY_W = LABEL_W + REG_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic [2:0]         fifo_push;
    logic [2:0]         fifo_pop;
    logic [2:0]         fifo_full;
    logic [2:0]         fifo_empty;
    logic [CNT_W-1:0]   fifo_count [3];
    logic [ENTRY_W-1:0] fifo_head  [3];

    logic               grant_valid;
    src_e               grant_sel;
    src_e               cand;
    logic [ENTRY_W-1:0] sel_head;

    cdb_word_t   cdb_q, cdb_d;
    src_e        grant_src_q, grant_src_d;
    logic [15:0] bcast_q, bcast_d;
    src_e        ptr_q, ptr_d;

    // Ready comes only from the registered occupancy, so a full FIFO
    // being drained this cycle still refuses the producer.
    assign add_ready = (fifo_count[SRC_ADD] < CNT_W'(FIFO_DEPTH));
    assign mul_ready = (fifo_count[SRC_MUL] < CNT_W'(FIFO_DEPTH));
    assign ld_ready  = (fifo_count[SRC_LD]  < CNT_W'(FIFO_DEPTH));

    assign fifo_push[SRC_ADD] = add_valid && !fifo_full[SRC_ADD];
    assign fifo_push[SRC_MUL] = mul_valid && !fifo_full[SRC_MUL];
    assign fifo_push[SRC_LD]  = ld_valid  && !fifo_full[SRC_LD];

    cdb_slot_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_add_fifo (
        .clk     (Clock),
        .rst_n   (Resetn),
        .push_i  (fifo_push[SRC_ADD]),
        .pop_i   (fifo_pop[SRC_ADD]),
        .data_i  ({add_label, add_reg, add_data}),
        .full_o  (fifo_full[SRC_ADD]),
        .empty_o (fifo_empty[SRC_ADD]),
        .count_o (fifo_count[SRC_ADD]),
        .head_o  (fifo_head[SRC_ADD])
    );

    cdb_slot_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_mul_fifo (
        .clk     (Clock),
        .rst_n   (Resetn),
        .push_i  (fifo_push[SRC_MUL]),
        .pop_i   (fifo_pop[SRC_MUL]),
        .data_i  ({mul_label, mul_reg, mul_data}),
        .full_o  (fifo_full[SRC_MUL]),
        .empty_o (fifo_empty[SRC_MUL]),
        .count_o (fifo_count[SRC_MUL]),
        .head_o  (fifo_head[SRC_MUL])
    );

    cdb_slot_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_ld_fifo (
        .clk     (Clock),
        .rst_n   (Resetn),
        .push_i  (fifo_push[SRC_LD]),
        .pop_i   (fifo_pop[SRC_LD]),
        .data_i  ({LD_LABEL, ld_reg, ld_data}),
        .full_o  (fifo_full[SRC_LD]),
        .empty_o (fifo_empty[SRC_LD]),
        .count_o (fifo_count[SRC_LD]),
        .head_o  (fifo_head[SRC_LD])
    );

    // Walk the three sources starting at the pointer; first non-empty wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = ptr_q;
        cand        = ptr_q;
        for (int i = 0; i < 3; i++) begin
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_sel   = cand;
            end
            cand = next_src(cand);
        end
    end

    assign fifo_pop[SRC_ADD] = grant_valid && (grant_sel == SRC_ADD);
    assign fifo_pop[SRC_MUL] = grant_valid && (grant_sel == SRC_MUL);
    assign fifo_pop[SRC_LD]  = grant_valid && (grant_sel == SRC_LD);

    always_comb begin
        case (grant_sel)
            SRC_MUL: sel_head = fifo_head[SRC_MUL];
            SRC_LD:  sel_head = fifo_head[SRC_LD];
            default: sel_head = fifo_head[SRC_ADD];
        endcase
    end

    // An idle cycle only drops the busy bit; the rest of the word is retained.
    always_comb begin
        cdb_d       = cdb_q;
        cdb_d.busy  = 1'b0;
        grant_src_d = grant_src_q;
        bcast_d     = bcast_q;
        ptr_d       = ptr_q;
        if (grant_valid) begin
            cdb_d       = pack_cdb(1'b1,
                                   grant_sel == SRC_MUL,
                                   sel_head[DATA_W+REG_W +: LABEL_W],
                                   sel_head[DATA_W +: REG_W],
                                   sel_head[DATA_W-1:0]);
            grant_src_d = grant_sel;
            bcast_d     = bcast_q + 16'd1;
            ptr_d       = next_src(grant_sel);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cdb_q       <= '0;
            grant_src_q <= SRC_ADD;
            bcast_q     <= '0;
            ptr_q       <= SRC_MUL;
        end else begin
            cdb_q       <= cdb_d;
            grant_src_q <= grant_src_d;
            bcast_q     <= bcast_d;
            ptr_q       <= ptr_d;
        end
    end

    assign cdbOut      = cdb_q;
    assign grant_src   = grant_src_q;
    assign bcast_count = bcast_q;

endmodule
